// File: rtl/dbte_mem_responder.sv
// AXI4 slave serving 128-bit DMA bound table entries from an on-chip table.
// Define DBTE_RESP_STATS_EN to add read/write beat and error-burst counters.
module dbte_mem_responder #(
    parameter logic [47:0] BASE_ADDR  = 48'h0,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [47:0]  s_axi_dbte_araddr,
    input  logic [1:0]   s_axi_dbte_arburst,
    input  logic [3:0]   s_axi_dbte_arcache,
    input  logic [7:0]   s_axi_dbte_arlen,
    input  logic         s_axi_dbte_arlock,
    input  logic [2:0]   s_axi_dbte_arprot,
    input  logic [3:0]   s_axi_dbte_arqos,
    input  logic [3:0]   s_axi_dbte_arregion,
    input  logic [2:0]   s_axi_dbte_arsize,
    input  logic         s_axi_dbte_arvalid,
    output logic         s_axi_dbte_arready,
    output logic [127:0] s_axi_dbte_rdata,
    output logic [1:0]   s_axi_dbte_rresp,
    output logic         s_axi_dbte_rlast,
    output logic         s_axi_dbte_rvalid,
    input  logic         s_axi_dbte_rready,
    input  logic [47:0]  s_axi_dbte_awaddr,
    input  logic [1:0]   s_axi_dbte_awburst,
    input  logic [3:0]   s_axi_dbte_awcache,
    input  logic [7:0]   s_axi_dbte_awlen,
    input  logic         s_axi_dbte_awlock,
    input  logic [2:0]   s_axi_dbte_awprot,
    input  logic [3:0]   s_axi_dbte_awqos,
    input  logic [3:0]   s_axi_dbte_awregion,
    input  logic [2:0]   s_axi_dbte_awsize,
    input  logic         s_axi_dbte_awvalid,
    output logic         s_axi_dbte_awready,
    input  logic [127:0] s_axi_dbte_wdata,
    input  logic [15:0]  s_axi_dbte_wstrb,
    input  logic         s_axi_dbte_wlast,
    input  logic         s_axi_dbte_wvalid,
    output logic         s_axi_dbte_wready,
    output logic [1:0]   s_axi_dbte_bresp,
    output logic         s_axi_dbte_bvalid,
    input  logic         s_axi_dbte_bready
`ifdef DBTE_RESP_STATS_EN
    ,
    output logic [31:0]  stat_rd_beats,
    output logic [31:0]  stat_wr_beats,
    output logic [15:0]  stat_err_bursts
`endif
);

    localparam int         DEPTH       = 2 ** DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic { R_IDLE, R_BURST } rState_t;
    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } wState_t;

    // A 49-bit difference exposes addresses below the window through its sign bit.
    function automatic logic [1:0] decodeErr(input logic [47:0] addr,
                                             input logic [2:0] size,
                                             input logic [1:0] burst);
        logic [48:0] diff;
        logic [47:0] offset;
        diff   = {1'b0, addr} - {1'b0, BASE_ADDR};
        offset = diff[47:0];
        if (diff[48] || ((offset >> (DEPTH_LOG2 + 4)) != 48'd0))
            return RESP_DECERR;
        else if ((size != 3'd4) || (burst[1] == 1'b1))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] decodeIdx(input logic [47:0] addr);
        logic [47:0] offset;
        offset = addr - BASE_ADDR;
        return offset[DEPTH_LOG2+3:4];
    endfunction

    logic [127:0] entries_q [DEPTH];

    rState_t               rState_q, rState_d;
    logic                  arReady_q, arReady_d;
    logic                  rValid_q, rValid_d;
    logic                  rLast_q, rLast_d;
    logic [127:0]          rData_q, rData_d;
    logic [1:0]            rResp_q, rResp_d;
    logic [DEPTH_LOG2-1:0] rIdx_q, rIdx_d;
    logic [7:0]            rLen_q, rLen_d;
    logic [7:0]            rBeat_q, rBeat_d;
    logic [1:0]            rBurst_q, rBurst_d;

    wState_t               wState_q, wState_d;
    logic                  awReady_q, awReady_d;
    logic                  wReady_q, wReady_d;
    logic                  bValid_q, bValid_d;
    logic [1:0]            bResp_q, bResp_d;
    logic [DEPTH_LOG2-1:0] wIdx_q, wIdx_d;
    logic [1:0]            wBurst_q, wBurst_d;
    logic [1:0]            wErr_q, wErr_d;

    logic [1:0]            arErr, awErr;
    logic [DEPTH_LOG2-1:0] arIdx, rNextIdx;
    logic                  arHs, rdHs, awHs, wrHs, bHs, memWe;
    logic                  unusedInputs;

    assign unusedInputs = ^{s_axi_dbte_arcache, s_axi_dbte_arlock, s_axi_dbte_arprot,
                            s_axi_dbte_arqos, s_axi_dbte_arregion, s_axi_dbte_awcache,
                            s_axi_dbte_awlock, s_axi_dbte_awprot, s_axi_dbte_awqos,
                            s_axi_dbte_awregion, s_axi_dbte_awlen};

    assign arErr    = decodeErr(s_axi_dbte_araddr, s_axi_dbte_arsize, s_axi_dbte_arburst);
    assign awErr    = decodeErr(s_axi_dbte_awaddr, s_axi_dbte_awsize, s_axi_dbte_awburst);
    assign arIdx    = decodeIdx(s_axi_dbte_araddr);
    assign rNextIdx = (rBurst_q == BURST_INCR) ? rIdx_q + 1'b1 : rIdx_q;

    assign arHs  = (rState_q == R_IDLE) && s_axi_dbte_arvalid && arReady_q;
    assign rdHs  = rValid_q && s_axi_dbte_rready;
    assign awHs  = (wState_q == W_IDLE) && s_axi_dbte_awvalid && awReady_q;
    assign wrHs  = (wState_q == W_DATA) && s_axi_dbte_wvalid && wReady_q;
    assign bHs   = bValid_q && s_axi_dbte_bready;
    assign memWe = wrHs && (wErr_q == RESP_OKAY);

    // Table contents survive reset; writes read the old value first because
    // the read side samples the table combinationally before this edge commits.
    always_ff @(posedge clock) begin
        if (memWe) begin
            for (int b = 0; b < 16; b++) begin
                if (s_axi_dbte_wstrb[b])
                    entries_q[wIdx_q][b*8 +: 8] <= s_axi_dbte_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rState_d  = rState_q;
        arReady_d = arReady_q;
        rValid_d  = rValid_q;
        rLast_d   = rLast_q;
        rData_d   = rData_q;
        rResp_d   = rResp_q;
        rIdx_d    = rIdx_q;
        rLen_d    = rLen_q;
        rBeat_d   = rBeat_q;
        rBurst_d  = rBurst_q;
        case (rState_q)
            R_IDLE: begin
                arReady_d = 1'b1;
                if (arHs) begin
                    arReady_d = 1'b0;
                    rIdx_d    = arIdx;
                    rLen_d    = s_axi_dbte_arlen;
                    rBurst_d  = s_axi_dbte_arburst;
                    rResp_d   = arErr;
                    rBeat_d   = 8'd0;
                    rValid_d  = 1'b1;
                    rLast_d   = (s_axi_dbte_arlen == 8'd0);
                    rData_d   = (arErr == RESP_OKAY) ? entries_q[arIdx] : '0;
                    rState_d  = R_BURST;
                end
            end
            R_BURST: begin
                if (rdHs) begin
                    if (rLast_q) begin
                        rValid_d  = 1'b0;
                        rLast_d   = 1'b0;
                        arReady_d = 1'b1;
                        rState_d  = R_IDLE;
                    end else begin
                        rIdx_d  = rNextIdx;
                        rBeat_d = rBeat_q + 8'd1;
                        rLast_d = ((rBeat_q + 8'd1) == rLen_q);
                        rData_d = (rResp_q == RESP_OKAY) ? entries_q[rNextIdx] : '0;
                    end
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rState_q  <= R_IDLE;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
            rLast_q   <= 1'b0;
            rData_q   <= '0;
            rResp_q   <= RESP_OKAY;
            rIdx_q    <= '0;
            rLen_q    <= 8'd0;
            rBeat_q   <= 8'd0;
            rBurst_q  <= 2'b00;
        end else begin
            rState_q  <= rState_d;
            arReady_q <= arReady_d;
            rValid_q  <= rValid_d;
            rLast_q   <= rLast_d;
            rData_q   <= rData_d;
            rResp_q   <= rResp_d;
            rIdx_q    <= rIdx_d;
            rLen_q    <= rLen_d;
            rBeat_q   <= rBeat_d;
            rBurst_q  <= rBurst_d;
        end
    end

    // The write burst ends on wlast alone; awlen is deliberately not tracked.
    always_comb begin
        wState_d  = wState_q;
        awReady_d = awReady_q;
        wReady_d  = wReady_q;
        bValid_d  = bValid_q;
        bResp_d   = bResp_q;
        wIdx_d    = wIdx_q;
        wBurst_d  = wBurst_q;
        wErr_d    = wErr_q;
        case (wState_q)
            W_IDLE: begin
                awReady_d = 1'b1;
                if (awHs) begin
                    awReady_d = 1'b0;
                    wReady_d  = 1'b1;
                    wIdx_d    = decodeIdx(s_axi_dbte_awaddr);
                    wBurst_d  = s_axi_dbte_awburst;
                    wErr_d    = awErr;
                    wState_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wrHs) begin
                    if (wBurst_q == BURST_INCR)
                        wIdx_d = wIdx_q + 1'b1;
                    if (s_axi_dbte_wlast) begin
                        wReady_d = 1'b0;
                        bValid_d = 1'b1;
                        bResp_d  = wErr_q;
                        wState_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bHs) begin
                    bValid_d  = 1'b0;
                    awReady_d = 1'b1;
                    wState_d  = W_IDLE;
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wState_q  <= W_IDLE;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bResp_q   <= RESP_OKAY;
            wIdx_q    <= '0;
            wBurst_q  <= 2'b00;
            wErr_q    <= RESP_OKAY;
        end else begin
            wState_q  <= wState_d;
            awReady_q <= awReady_d;
            wReady_q  <= wReady_d;
            bValid_q  <= bValid_d;
            bResp_q   <= bResp_d;
            wIdx_q    <= wIdx_d;
            wBurst_q  <= wBurst_d;
            wErr_q    <= wErr_d;
        end
    end

    assign s_axi_dbte_arready = arReady_q;
    assign s_axi_dbte_rvalid  = rValid_q;
    assign s_axi_dbte_rlast   = rLast_q;
    assign s_axi_dbte_rdata   = rData_q;
    assign s_axi_dbte_rresp   = rResp_q;
    assign s_axi_dbte_awready = awReady_q;
    assign s_axi_dbte_wready  = wReady_q;
    assign s_axi_dbte_bvalid  = bValid_q;
    assign s_axi_dbte_bresp   = bResp_q;

`ifdef DBTE_RESP_STATS_EN
    logic [31:0] rdBeats_q, wrBeats_q;
    logic [15:0] errBursts_q;
    logic [1:0]  errInc;

    assign errInc = {1'b0, arHs && (arErr != RESP_OKAY)} +
                    {1'b0, awHs && (awErr != RESP_OKAY)};

    // Both channels may latch an error burst in one cycle, so the error count can step by two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdBeats_q   <= 32'd0;
            wrBeats_q   <= 32'd0;
            errBursts_q <= 16'd0;
        end else begin
            if (rdHs && (rdBeats_q != 32'hFFFF_FFFF))
                rdBeats_q <= rdBeats_q + 32'd1;
            if (wrHs && (wrBeats_q != 32'hFFFF_FFFF))
                wrBeats_q <= wrBeats_q + 32'd1;
            if (errInc != 2'd0)
                errBursts_q <= (errBursts_q > (16'hFFFF - {14'd0, errInc})) ?
                               16'hFFFF : errBursts_q + {14'd0, errInc};
        end
    end

    assign stat_rd_beats   = rdBeats_q;
    assign stat_wr_beats   = wrBeats_q;
    assign stat_err_bursts = errBursts_q;
`endif

endmodule

// File: tb/tb_dbte_mem_responder.sv
// Directed self-checking bench for dbte_mem_responder: reset, bursts, strobes,
// FIXED/wrap indexing, error responses, read-first collisions and backpressure.
module tb_dbte_mem_responder;

    localparam logic [47:0] BASE = 48'h0000_8000_0000;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [47:0]  araddr = '0, awaddr = '0;
    logic [1:0]   arburst = '0, awburst = '0;
    logic [7:0]   arlen = '0, awlen = '0;
    logic [2:0]   arsize = '0, awsize = '0;
    logic         arvalid = 1'b0, awvalid = 1'b0;
    logic         arready, awready;
    logic [127:0] rdata;
    logic [1:0]   rresp, bresp;
    logic         rlast, rvalid, bvalid, wready;
    logic         rready = 1'b0, bready = 1'b0;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '0;
    logic         wlast = 1'b0, wvalid = 1'b0;
`ifdef DBTE_RESP_STATS_EN
    logic [31:0]  statRd, statWr;
    logic [15:0]  statErr;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    logic [127:0] wBeatData [16];
    logic [15:0]  wBeatStrb [16];
    logic [127:0] rBeatData [16];
    logic [1:0]   rBeatResp [16];
    logic         rBeatLast [16];
    int           rBeatCount;
    logic         rFirstValid;

    always #5 clock = ~clock;

    dbte_mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(8)) dut (
        .clock(clock), .reset(reset),
        .s_axi_dbte_araddr(araddr), .s_axi_dbte_arburst(arburst), .s_axi_dbte_arcache(4'd0),
        .s_axi_dbte_arlen(arlen), .s_axi_dbte_arlock(1'b0), .s_axi_dbte_arprot(3'd0),
        .s_axi_dbte_arqos(4'd0), .s_axi_dbte_arregion(4'd0), .s_axi_dbte_arsize(arsize),
        .s_axi_dbte_arvalid(arvalid), .s_axi_dbte_arready(arready),
        .s_axi_dbte_rdata(rdata), .s_axi_dbte_rresp(rresp), .s_axi_dbte_rlast(rlast),
        .s_axi_dbte_rvalid(rvalid), .s_axi_dbte_rready(rready),
        .s_axi_dbte_awaddr(awaddr), .s_axi_dbte_awburst(awburst), .s_axi_dbte_awcache(4'd0),
        .s_axi_dbte_awlen(awlen), .s_axi_dbte_awlock(1'b0), .s_axi_dbte_awprot(3'd0),
        .s_axi_dbte_awqos(4'd0), .s_axi_dbte_awregion(4'd0), .s_axi_dbte_awsize(awsize),
        .s_axi_dbte_awvalid(awvalid), .s_axi_dbte_awready(awready),
        .s_axi_dbte_wdata(wdata), .s_axi_dbte_wstrb(wstrb), .s_axi_dbte_wlast(wlast),
        .s_axi_dbte_wvalid(wvalid), .s_axi_dbte_wready(wready),
        .s_axi_dbte_bresp(bresp), .s_axi_dbte_bvalid(bvalid), .s_axi_dbte_bready(bready)
`ifdef DBTE_RESP_STATS_EN
        ,
        .stat_rd_beats(statRd), .stat_wr_beats(statWr), .stat_err_bursts(statErr)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one AR and collects beats until rlast, optionally with random rready.
    task automatic readBurst(input logic [47:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input bit randReady);
        int  n;
        bit  done;
        araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        if (!arready) begin
            testsRun++; testsFailed++;
            $display("[TB] FAIL ar_timeout: arready=%0b required 1", arready);
            arvalid = 1'b0;
            return;
        end
        tick();
        arvalid = 1'b0;
        rFirstValid = rvalid;
        rBeatCount = 0;
        done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            rready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid && rready) begin
                if (rBeatCount < 16) begin
                    rBeatData[rBeatCount] = rdata;
                    rBeatResp[rBeatCount] = rresp;
                    rBeatLast[rBeatCount] = rlast;
                end
                rBeatCount++;
                if (rlast) done = 1'b1;
            end
            tick();
            n++;
        end
        rready = 1'b0;
        if (!done) begin
            testsRun++; testsFailed++;
            $display("[TB] FAIL r_timeout: beats=%0d rlast never seen", rBeatCount);
        end
    endtask

    // Issues one AW, sends wBeatData/wBeatStrb beats, then collects the B response.
    task automatic writeBurst(input logic [47:0] addr, input int nBeats, input logic [1:0] burst,
                              input logic [2:0] size, input bit randBp, output logic [1:0] resp);
        int n;
        bit done;
        resp = 2'b01;
        awaddr = addr; awlen = 8'(nBeats - 1); awburst = burst; awsize = size; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        if (!awready) begin
            testsRun++; testsFailed++;
            $display("[TB] FAIL aw_timeout: awready=%0b required 1", awready);
            awvalid = 1'b0;
            return;
        end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < nBeats; i++) begin
            if (randBp) repeat ($urandom_range(0, 2)) tick();
            wdata = wBeatData[i]; wstrb = wBeatStrb[i]; wlast = (i == nBeats - 1); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            if (!wready) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL w_timeout: wready=%0b required 1 at beat %0d", wready, i);
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            tick();
            wvalid = 1'b0; wlast = 1'b0;
        end
        done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            bready = randBp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bvalid && bready) begin resp = bresp; done = 1'b1; end
            tick();
            n++;
        end
        bready = 1'b0;
        if (!done) begin
            testsRun++; testsFailed++;
            $display("[TB] FAIL b_timeout: bvalid never handshaken");
        end
    endtask

    task automatic test_reset();
        #3;
        testsRun++;
        if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b required 000000", {arready, awready, wready, rvalid, bvalid, rlast});
        end
        testsRun++;
        if ({rdata, rresp, bresp} !== 132'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: rdata=%h rresp=%b bresp=%b required zeros", rdata, rresp, bresp);
        end
        tick();
        reset = 1'b1;
        tick();
        testsRun++;
        if ({arready, awready, wready} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_ready: ar/aw/w=%b required 110", {arready, awready, wready});
        end
    endtask

    task automatic test_write_read();
        logic [1:0] resp;
        logic [127:0] valA = 128'hAAAA_0001_1111_2222_3333_4444_5555_6666;
        logic [127:0] valB = 128'hBBBB_0002_7777_8888_9999_AAAA_BBBB_CCCC;
        wBeatData[0] = valA; wBeatStrb[0] = 16'hFFFF;
        wBeatData[1] = valB; wBeatStrb[1] = 16'hFFFF;
        writeBurst(BASE + 48'h20, 2, 2'b01, 3'd4, 1'b0, resp);
        testsRun++;
        if (resp !== 2'b00) begin testsFailed++; $display("[TB] FAIL wr_bresp: got %b required 00", resp); end
        readBurst(BASE + 48'h20, 8'd1, 2'b01, 3'd4, 1'b0);
        testsRun++;
        if (rFirstValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rd_latency: rvalid=%b one cycle after ar, required 1", rFirstValid); end
        testsRun++;
        if (rBeatCount != 2) begin testsFailed++; $display("[TB] FAIL rd_count: got %0d required 2", rBeatCount); end
        testsRun++;
        if (rBeatData[0] !== valA || rBeatData[1] !== valB) begin
            testsFailed++;
            $display("[TB] FAIL rd_data: got %h,%h required %h,%h", rBeatData[0], rBeatData[1], valA, valB);
        end
        testsRun++;
        if ({rBeatLast[0], rBeatLast[1], rBeatResp[0], rBeatResp[1]} !== 6'b01_0000) begin
            testsFailed++;
            $display("[TB] FAIL rd_last_resp: last=%b%b resp=%b,%b required 01 and 00,00", rBeatLast[0], rBeatLast[1], rBeatResp[0], rBeatResp[1]);
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp;
        wBeatData[0] = '1; wBeatStrb[0] = 16'hFFFF;
        writeBurst(BASE + 48'h50, 1, 2'b01, 3'd4, 1'b0, resp);
        wBeatData[0] = '0; wBeatStrb[0] = 16'h00FF;
        writeBurst(BASE + 48'h50, 1, 2'b01, 3'd4, 1'b0, resp);
        readBurst(BASE + 48'h50, 8'd0, 2'b01, 3'd4, 1'b0);
        testsRun++;
        if (rBeatData[0] !== 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL partial_strobe: got %h required ffffffffffffffff0000000000000000", rBeatData[0]);
        end
    endtask

    task automatic test_fixed_wrap();
        logic [1:0] resp;
        logic [127:0] valC = 128'hC0C0_C0C0_0000_0007_1234_5678_9ABC_DEF0;
        logic [127:0] valD = 128'hD0D0_0000_0000_00FF_0000_0000_0000_00FF;
        logic [127:0] valE = 128'hE0E0_0000_0000_0000_0000_0000_0000_0E0E;
        wBeatData[0] = valC; wBeatStrb[0] = 16'hFFFF;
        writeBurst(BASE + 48'h70, 1, 2'b01, 3'd4, 1'b0, resp);
        readBurst(BASE + 48'h70, 8'd3, 2'b00, 3'd4, 1'b0);
        testsRun++;
        if (rBeatCount != 4) begin testsFailed++; $display("[TB] FAIL fixed_count: got %0d required 4", rBeatCount); end
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (rBeatData[i] !== valC || rBeatLast[i] !== (i == 3)) begin
                testsFailed++;
                $display("[TB] FAIL fixed_beat%0d: data=%h last=%b required %h last=%b", i, rBeatData[i], rBeatLast[i], valC, (i == 3));
            end
        end
        wBeatData[0] = valD; wBeatStrb[0] = 16'hFFFF;
        wBeatData[1] = valE; wBeatStrb[1] = 16'hFFFF;
        writeBurst(BASE + 48'hFF0, 2, 2'b01, 3'd4, 1'b0, resp);
        readBurst(BASE + 48'hFF0, 8'd1, 2'b01, 3'd4, 1'b0);
        testsRun++;
        if (rBeatCount != 2 || rBeatData[0] !== valD || rBeatData[1] !== valE || rBeatResp[1] !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL incr_wrap: n=%0d got %h,%h resp=%b required %h,%h 00", rBeatCount, rBeatData[0], rBeatData[1], rBeatResp[1], valD, valE);
        end
        readBurst(BASE, 8'd0, 2'b01, 3'd4, 1'b0);
        testsRun++;
        if (rBeatData[0] !== valE) begin testsFailed++; $display("[TB] FAIL write_wrap: entry0=%h required %h", rBeatData[0], valE); end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        readBurst(BASE + 48'h1000, 8'd0, 2'b01, 3'd4, 1'b0);
        testsRun++;
        if (rBeatCount != 1 || rBeatResp[0] !== 2'b11 || rBeatData[0] !== 128'd0 || rBeatLast[0] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rd_decerr: n=%0d resp=%b data=%h last=%b required 1 11 0 1", rBeatCount, rBeatResp[0], rBeatData[0], rBeatLast[0]);
        end
        readBurst(BASE - 48'h10, 8'd0, 2'b01, 3'd4, 1'b0);
        testsRun++;
        if (rBeatResp[0] !== 2'b11) begin testsFailed++; $display("[TB] FAIL rd_below_base: resp=%b required 11", rBeatResp[0]); end
        readBurst(BASE + 48'h20, 8'd0, 2'b01, 3'd3, 1'b0);
        testsRun++;
        if (rBeatResp[0] !== 2'b10 || rBeatData[0] !== 128'd0) begin
            testsFailed++;
            $display("[TB] FAIL rd_size_slverr: resp=%b data=%h required 10 0", rBeatResp[0], rBeatData[0]);
        end
        readBurst(BASE + 48'h1000, 8'd0, 2'b01, 3'd3, 1'b0);
        testsRun++;
        if (rBeatResp[0] !== 2'b11) begin testsFailed++; $display("[TB] FAIL rd_decerr_priority: resp=%b required 11", rBeatResp[0]); end
        readBurst(BASE + 48'h20, 8'd1, 2'b10, 3'd4, 1'b0);
        testsRun++;
        if (rBeatCount != 2 || rBeatResp[0] !== 2'b10 || rBeatResp[1] !== 2'b10 || rBeatData[1] !== 128'd0) begin
            testsFailed++;
            $display("[TB] FAIL rd_wrap_slverr: n=%0d resp=%b,%b data=%h required 2 10,10 0", rBeatCount, rBeatResp[0], rBeatResp[1], rBeatData[1]);
        end
        wBeatData[0] = 128'hF00D_F00D_F00D_F00D_F00D_F00D_F00D_F00D; wBeatStrb[0] = 16'hFFFF;
        writeBurst(BASE + 48'h20, 1, 2'b10, 3'd4, 1'b0, resp);
        testsRun++;
        if (resp !== 2'b10) begin testsFailed++; $display("[TB] FAIL wr_wrap_slverr: bresp=%b required 10", resp); end
        readBurst(BASE + 48'h20, 8'd0, 2'b01, 3'd4, 1'b0);
        testsRun++;
        if (rBeatData[0] !== 128'hAAAA_0001_1111_2222_3333_4444_5555_6666) begin
            testsFailed++;
            $display("[TB] FAIL wr_err_suppressed: entry=%h required aaaa0001111122223333444455556666", rBeatData[0]);
        end
        writeBurst(BASE + 48'h2000, 1, 2'b01, 3'd4, 1'b0, resp);
        testsRun++;
        if (resp !== 2'b11) begin testsFailed++; $display("[TB] FAIL wr_decerr: bresp=%b required 11", resp); end
    endtask

    task automatic test_w_before_aw();
        wdata = 128'h1; wstrb = 16'hFFFF; wlast = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (wready !== 1'b0 || bvalid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL w_held_off: wready=%b bvalid=%b required 0 0", wready, bvalid);
            end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic test_same_index();
        logic [1:0] resp;
        logic [127:0] oldVal = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        logic [127:0] newVal = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;
        wBeatData[0] = oldVal; wBeatStrb[0] = 16'hFFFF;
        writeBurst(BASE + 48'h90, 1, 2'b01, 3'd4, 1'b0, resp);
        araddr = BASE + 48'h90; arlen = 8'd2; arburst = 2'b00; arsize = 3'd4; arvalid = 1'b1;
        awaddr = BASE + 48'h90; awlen = 8'd0; awburst = 2'b01; awsize = 3'd4; awvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0;
        rready = 1'b1;
        wdata = newVal; wstrb = 16'hFFFF; wlast = 1'b1; wvalid = 1'b1;
        testsRun++;
        if (rvalid !== 1'b1 || wready !== 1'b1 || rdata !== oldVal) begin
            testsFailed++;
            $display("[TB] FAIL same_idx_beat0: rvalid=%b wready=%b rdata=%h required 1 1 %h", rvalid, wready, rdata, oldVal);
        end
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        testsRun++;
        if (rvalid !== 1'b1 || rdata !== oldVal) begin
            testsFailed++;
            $display("[TB] FAIL same_idx_read_first: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, oldVal);
        end
        tick();
        testsRun++;
        if (rdata !== newVal || rlast !== 1'b1 || bvalid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL same_idx_next_beat: rdata=%h rlast=%b bvalid=%b required %h 1 1", rdata, rlast, bvalid, newVal);
        end
        tick();
        rready = 1'b0;
        testsRun++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL same_idx_done: rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp;
        logic [127:0] oldVals [4];
        logic [127:0] newVals [4];
        for (int i = 0; i < 4; i++) begin
            oldVals[i] = {32'h0100_0000 + 32'(i), 96'h5A5A_5A5A_0000_0000_1111_0000};
            newVals[i] = {32'h0200_0000 + 32'(i), 96'hA5A5_A5A5_FFFF_0000_2222_0000};
            wBeatData[i] = oldVals[i]; wBeatStrb[i] = 16'hFFFF;
        end
        writeBurst(BASE + 48'h100, 4, 2'b01, 3'd4, 1'b0, resp);
        for (int i = 0; i < 4; i++) wBeatData[i] = newVals[i];
        fork
            readBurst(BASE + 48'h100, 8'd3, 2'b01, 3'd4, 1'b1);
            writeBurst(BASE + 48'h140, 4, 2'b01, 3'd4, 1'b1, resp);
        join
        testsRun++;
        if (rBeatCount != 4) begin testsFailed++; $display("[TB] FAIL bp_rd_count: got %0d required 4", rBeatCount); end
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (rBeatData[i] !== oldVals[i] || rBeatLast[i] !== (i == 3)) begin
                testsFailed++;
                $display("[TB] FAIL bp_rd_beat%0d: data=%h last=%b required %h last=%b", i, rBeatData[i], rBeatLast[i], oldVals[i], (i == 3));
            end
        end
        testsRun++;
        if (resp !== 2'b00) begin testsFailed++; $display("[TB] FAIL bp_wr_bresp: got %b required 00", resp); end
        readBurst(BASE + 48'h140, 8'd3, 2'b01, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (rBeatData[i] !== newVals[i]) begin
                testsFailed++;
                $display("[TB] FAIL bp_wr_beat%0d: data=%h required %h", i, rBeatData[i], newVals[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int stale;
        araddr = BASE + 48'h200; arlen = 8'd3; arburst = 2'b01; arsize = 3'd4; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        testsRun++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 128'd0 || arready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_burst: rvalid=%b rlast=%b rdata=%h arready=%b required 0 0 0 0", rvalid, rlast, rdata, arready);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        testsRun++;
        if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_release_arready: got %b required 1", arready); end
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            if (rvalid) stale++;
            tick();
        end
        rready = 1'b0;
        testsRun++;
        if (stale != 0) begin testsFailed++; $display("[TB] FAIL reset_stale_beats: got %0d required 0", stale); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_fixed_wrap();
        test_errors();
        test_w_before_aw();
        test_same_index();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dbte_mem_responder.md
Name: dbte_mem_responder

Overview:
- AXI4 slave that answers the checker's DBTE master port (48-bit address, 128-bit data, no ID) from an on-chip table of 128-bit DMA bound table entries.
- Used as a standalone table store in simulation and FPGA bring-up, in place of system memory.
- Independent read and write channels.
- Supports FIXED and INCR bursts; rejects bad accesses with AXI error responses.

Parameters:
- BASE_ADDR, 48'h0, byte base address of the table window.
- DEPTH_LOG2, 8, log2 of the entry count (256 entries x 16 B = 4 KiB window).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- s_axi_dbte_ar{addr,burst,cache,len,lock,prot,qos,region,size,valid}  in  48/2/4/8/1/3/4/4/3/1  read address; ar{cache,lock,prot,qos,region} are ignored.
- s_axi_dbte_arready  out  1  read address ready.
- s_axi_dbte_r{data,resp,last,valid}  out  128/2/1/1  read data.
- s_axi_dbte_rready  in  1  read data ready.
- s_axi_dbte_aw{addr,burst,cache,len,lock,prot,qos,region,size,valid}  in  same widths as AR  write address; aw{cache,lock,prot,qos,region} are ignored.
- s_axi_dbte_awready  out  1  write address ready.
- s_axi_dbte_w{data,strb,last,valid}  in  128/16/1/1  write data.
- s_axi_dbte_wready  out  1  write data ready.
- s_axi_dbte_b{resp,valid}  out  2/1  write response.
- s_axi_dbte_bready  in  1  write response ready.

Behaviour:
- Reset values (reset low): arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rdata=0, rresp=0, bresp=0.
- Reset does not clear table contents.
- Reset asserted mid-burst aborts the burst immediately. No R/B beat is produced after reset; the table keeps only the beats already written.
- Address decode:
  - offset = addr - BASE_ADDR; index = offset[DEPTH_LOG2+3:4].
  - The address is in range when addr >= BASE_ADDR and offset < 2^(DEPTH_LOG2+4).
  - Bits [3:0] are ignored.
- Read FSM, states R_IDLE -> R_BURST -> R_IDLE:
  - R_IDLE: arready=1. On ar handshake, latch index, len, burst and an error code, then go to R_BURST.
  - The first rvalid appears the cycle after the ar handshake (1-cycle latency); rdata is registered.
  - R_BURST: holds rvalid and rdata stable until rready.
  - Index step per beat: INCR advances by 1 per beat, wrapping modulo DEPTH. FIXED does not advance.
  - rlast=1 on beat len (len+1 beats in total). On the rlast handshake, go to R_IDLE; arready re-asserts the next cycle.
  - Back-to-back beats: rvalid stays high when rready=1 every cycle (full throughput).
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. The aw handshake latches index, burst and error.
  - W_DATA: wready=1. Each w handshake updates the bytes selected by wstrb at the current index, then advances the index per burst rules. Error bursts suppress the writes.
  - On the handshake with wlast=1, go to W_RESP. wlast is not checked against awlen: wlast alone ends the burst.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
  - A W beat presented before its AW is held off (wready=0 in W_IDLE).
- Error codes, latched per burst; data is returned as zero on error:
  - Out of range: DECERR (2'b11).
  - size != 3'd4, or burst == WRAP(2) or reserved(3): SLVERR (2'b10).
  - DECERR takes priority.
  - Every beat of an erroring read carries the same resp. Otherwise resp = OKAY (2'b00).
- INCR index overflow past DEPTH-1 wraps to 0 and is not flagged as an error.
- Same-cycle read beat and write beat to the same index: read-first, so R returns the pre-write data. The write is visible to the next beat or burst.
- Read and write channels never stall each other.

Optional Feature:
- Macro: DBTE_RESP_STATS_EN.
- Defined: adds outputs stat_rd_beats (32-bit), stat_wr_beats (32-bit) and stat_err_bursts (16-bit), all reset to 0.
  - stat_rd_beats counts R handshakes; stat_wr_beats counts W handshakes.
  - stat_err_bursts counts ar/aw handshakes latched with a non-OKAY code.
  - All counters saturate at their maximum value.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-burst: during a 4-beat read, pull reset low at beat 2 -> rvalid=0 asynchronously; after release arready=1 and no stale beats appear.
- Write then read: awaddr=BASE+0x20, len=1, INCR, data {A,B}, wstrb=16'hFFFF -> bresp=0. Then araddr=BASE+0x20, len=1 -> rdata A, then B with rlast on beat 1, first rvalid 1 cycle after the ar handshake.
- Partial strobe: entry 5 = all ones; write 0 with wstrb=16'h00FF -> read returns 128'hFFFF..FF_0000000000000000.
- FIXED and wrap: FIXED read len=3 at index 7 -> 4 identical beats. INCR read at index 255, len=1 -> entries 255 then 0.
- Errors: araddr=BASE+0x1000 -> single beat with rresp=2'b11, rdata=0. arsize=3 -> rresp=2'b10. WRAP write -> bresp=2'b10 and the table is unchanged.
- Stress: random rready/bready backpressure, with simultaneous same-index read and write -> read returns old data. Scoreboard matches and there are no dropped or duplicated beats.
